// File: rtl/freq_gate_sequencer.sv
// -----------------------------------------------------------------------------
// freq_gate_sequencer
//
// Drives the frequency-counter datapath through repeated measurement cycles:
//   CLEAR -> GATE -> SETTLE -> LATCH -> HOLD -> (CLEAR | IDLE)
// The gate length auto-ranges over four decades. An overflow during the gate
// moves to a shorter gate and restarts the cycle. A low count at latch time
// moves to a longer gate for the next cycle.
//
// Parameters
//   GATE_BASE     gate length in clck cycles at range 0 (multiple of 1000)
//   SETTLE_CYCLES idle cycles between gate close and latch (>= 1)
//   HOLD_CYCLES   display hold cycles after latch (>= 1)
//   TW            cycle timer width; must hold max(GATE_BASE, HOLD_CYCLES)
//
// Ports
//   clck     in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   run      in   continuous mode (level)
//   single   in   one-shot start pulse, honoured only while idle
//   cnt_ovf  in   counter saturated, looked at only during GATE
//   cnt_low  in   count below 10% of full scale, looked at only during LATCH
//   gate     out  counter enable window
//   cnt_clr  out  counter clear pulse
//   latch    out  display register load pulse
//   done     out  measurement complete pulse (same cycle as latch)
//   busy     out  high in every state except IDLE
//   range    out  current gate decade (0 = longest gate)
//   ovf_err  out  last latched value saturated at range 3
//
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module freq_gate_sequencer #(
   parameter int GATE_BASE     = 1000,
   parameter int SETTLE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 20,
   parameter int TW            = 32
) (
   input  logic       clck,
   input  logic       rst_n,
   input  logic       run,
   input  logic       single,
   input  logic       cnt_ovf,
   input  logic       cnt_low,
   output logic       gate,
   output logic       cnt_clr,
   output logic       latch,
   output logic       done,
   output logic       busy,
   output logic [1:0] range,
   output logic       ovf_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_GATE   = 3'd2,
      S_SETTLE = 3'd3,
      S_LATCH  = 3'd4,
      S_HOLD   = 3'd5
   } state_t;

   localparam logic [TW-1:0] SETTLE_LEN = TW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] HOLD_LEN   = TW'(HOLD_CYCLES);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

   state_t        state_reg, state_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic [1:0]    range_reg, range_next;
   logic          sat_reg, sat_next;
   logic          ovf_err_reg, ovf_err_next;

   // Gate length per decade: GATE_BASE / 10^r.
   logic [TW-1:0] gate_tbl [4];
   logic [TW-1:0] gate_len;

   for (genvar gi = 0; gi < 4; gi++) begin : g_gate_len
      assign gate_tbl[gi] = TW'(GATE_BASE / (10 ** gi));
   end

   assign gate_len = gate_tbl[range_reg];

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clck or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         timer_reg   <= '0;
         range_reg   <= 2'd0;
         sat_reg     <= 1'b0;
         ovf_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         range_reg   <= range_next;
         sat_reg     <= sat_next;
         ovf_err_reg <= ovf_err_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // The timer is loaded with the length of the state being entered and
   // counts down to 1; the state is left on the cycle it reads 1.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg;
      range_next   = range_reg;
      sat_next     = sat_reg;
      ovf_err_next = ovf_err_reg;

      case (state_reg)
         S_IDLE: begin
            if (run || single) begin
               state_next = S_CLEAR;
               sat_next   = 1'b0;
            end
         end

         S_CLEAR: begin
            state_next = S_GATE;
            timer_next = gate_len;
         end

         S_GATE: begin
            // Overflow wins over a simultaneous timer expiry.
            if (cnt_ovf) begin
               if (range_reg != 2'd3) begin
                  // Shorter gate, restart without latching.
                  range_next = range_reg + 2'd1;
                  state_next = S_CLEAR;
                  sat_next   = 1'b0;
                  timer_next = '0;
               end else begin
                  // Already at the shortest gate: finish and flag it.
                  sat_next   = 1'b1;
                  state_next = S_SETTLE;
                  timer_next = SETTLE_LEN;
               end
            end else if (timer_reg <= TIMER_ONE) begin
               state_next = S_SETTLE;
               timer_next = SETTLE_LEN;
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end

         S_SETTLE: begin
            if (timer_reg <= TIMER_ONE) begin
               state_next   = S_LATCH;
               timer_next   = '0;
               // Loaded on entry so ovf_err is valid alongside the latch pulse.
               ovf_err_next = sat_reg;
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end

         S_LATCH: begin
            // Low count: lengthen the gate for the next cycle, unless the
            // reading was a saturated one.
            if (cnt_low && (range_reg != 2'd0) && !sat_reg) begin
               range_next = range_reg - 2'd1;
            end
            state_next = S_HOLD;
            timer_next = HOLD_LEN;
         end

         S_HOLD: begin
            if (timer_reg <= TIMER_ONE) begin
               timer_next = '0;
               if (run) begin
                  state_next = S_CLEAR;
                  sat_next   = 1'b0;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end

         default: begin
            state_next = S_IDLE;
            timer_next = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output decode (registered state only)
   // -------------------------------------------------------------------------
   assign gate    = (state_reg == S_GATE);
   assign cnt_clr = (state_reg == S_CLEAR);
   assign latch   = (state_reg == S_LATCH);
   assign done    = (state_reg == S_LATCH);
   assign busy    = (state_reg != S_IDLE);
   assign range   = range_reg;
   assign ovf_err = ovf_err_reg;

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_sequencer
//
// Self-checking bench. Each started measurement pushes its expected latch
// record (ovf_err, range, preceding gate width) to a queue; the monitor pops
// and compares on every latch pulse. Timing offsets, range moves and reset
// behaviour are checked directly from the scenario code.
// -----------------------------------------------------------------------------
module tb_freq_gate_sequencer;

   logic       clck;
   logic       rst_n;
   logic       run;
   logic       single;
   logic       cnt_ovf;
   logic       cnt_low;
   logic       gate;
   logic       cnt_clr;
   logic       latch;
   logic       done;
   logic       busy;
   logic [1:0] range;
   logic       ovf_err;

   freq_gate_sequencer dut (
      .clck    (clck),
      .rst_n   (rst_n),
      .run     (run),
      .single  (single),
      .cnt_ovf (cnt_ovf),
      .cnt_low (cnt_low),
      .gate    (gate),
      .cnt_clr (cnt_clr),
      .latch   (latch),
      .done    (done),
      .busy    (busy),
      .range   (range),
      .ovf_err (ovf_err)
   );

   initial clck = 1'b0;
   always #5 clck = ~clck;

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) begin
         n_pass++;
         $display("ok   %-22s got %0d", tag, obs);
      end else begin
         $display("FAIL %-22s got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // ------------------------------------------------------------------
   // Scoreboard and monitor
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        ovf;
      logic [1:0]  rng;
      logic [31:0] glen;
   } exp_t;

   exp_t exp_q [$];
   exp_t exp_e;

   int cyc = 0;             // number of rising edges so far
   int gate_run = 0;
   int last_gate_len = 0;
   int gate_first = 0;
   int gate_last = 0;
   int clr_at = 0;
   int clr_cnt = 0;
   int latch_at = 0;
   int idle_at = 0;
   int n_latch = 0;
   int latch_times [$];
   logic busy_prev = 1'b0;

   always @(posedge clck) cyc++;

   // Samples at the falling edge; 'label' is the rising edge that will
   // sample this value.
   always @(negedge clck) begin
      int label;
      label = cyc + 1;
      if (cnt_clr) begin
         clr_at = label;
         clr_cnt++;
      end
      if (gate) begin
         if (gate_run == 0) gate_first = label;
         gate_run++;
         gate_last = label;
      end else if (gate_run != 0) begin
         last_gate_len = gate_run;
         gate_run = 0;
      end
      if (busy_prev && !busy) idle_at = label;
      busy_prev = busy;
      if (latch) begin
         latch_at = label;
         latch_times.push_back(label);
         n_latch++;
         if (exp_q.size() == 0) begin
            check("unexpected_latch", 32'd1, 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check("latch_ovf_err", 32'(ovf_err), 32'(exp_e.ovf));
            check("latch_range", 32'(range), 32'(exp_e.rng));
            check("latch_gate_len", last_gate_len, exp_e.glen);
            check("done_with_latch", 32'(done), 32'd1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   int t_start = 0;

   task automatic push_exp(input logic ovf, input logic [1:0] rng, input int glen);
      exp_t e;
      e.ovf  = ovf;
      e.rng  = rng;
      e.glen = glen;
      exp_q.push_back(e);
   endtask

   task automatic pulse_single();
      @(negedge clck);
      single  = 1'b1;
      t_start = cyc + 1;
      @(negedge clck);
      single  = 1'b0;
   endtask

   task automatic wait_gate_cycles(input int n);
      int cnt = 0;
      int budget = 5000;
      while (cnt < n && budget > 0) begin
         @(negedge clck);
         budget--;
         if (gate) cnt++;
      end
      if (cnt < n) check("wait_gate_timeout", 32'd0, 32'd1);
   endtask

   task automatic inject_ovf(input int n);
      wait_gate_cycles(n);
      cnt_ovf = 1'b1;
      @(negedge clck);
      cnt_ovf = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int b = budget;
      while (busy && b > 0) begin
         @(negedge clck);
         b--;
      end
      if (busy) check("wait_idle_timeout", 32'd0, 32'd1);
      #1;
   endtask

   task automatic wait_latch(input int budget);
      int b = budget;
      do begin
         @(negedge clck);
         b--;
      end while (!latch && b > 0);
      if (!latch) check("wait_latch_timeout", 32'd0, 32'd1);
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   initial begin
      int c0;
      int n0;
      int rises;
      int budget;
      logic prev;

      rst_n   = 1'b0;
      run     = 1'b0;
      single  = 1'b0;
      cnt_ovf = 1'b0;
      cnt_low = 1'b0;

      // Reset state
      repeat (3) @(negedge clck);
      check("rst_gate", 32'(gate), 32'd0);
      check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
      check("rst_latch", 32'(latch), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_range", 32'(range), 32'd0);
      check("rst_ovf_err", 32'(ovf_err), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clck);
      check("idle_no_start", 32'(busy), 32'd0);

      // Single shot at range 0
      push_exp(1'b0, 2'd0, 1000);
      c0 = clr_cnt;
      pulse_single();
      wait_idle(2000);
      check("ss_clr_offset", clr_at - t_start, 32'd1);
      check("ss_gate_first", gate_first - t_start, 32'd2);
      check("ss_gate_last", gate_last - t_start, 32'd1001);
      check("ss_latch_offset", latch_at - t_start, 32'd1004);
      check("ss_idle_offset", idle_at - t_start, 32'd1025);
      check("ss_clr_count", clr_cnt - c0, 32'd1);
      check("ss_range", 32'(range), 32'd0);

      // Continuous mode, run dropped during the third gate
      repeat (3) push_exp(1'b0, 2'd0, 1000);
      n0 = latch_times.size();
      @(negedge clck);
      run    = 1'b1;
      rises  = 0;
      prev   = 1'b0;
      budget = 5000;
      while (rises < 3 && budget > 0) begin
         @(negedge clck);
         budget--;
         if (gate && !prev) rises++;
         prev = gate;
      end
      repeat (10) @(negedge clck);
      run = 1'b0;
      wait_idle(3000);
      check("cont_latch_count", latch_times.size() - n0, 32'd3);
      if (latch_times.size() >= n0 + 3) begin
         check("cont_interval_1", latch_times[n0 + 1] - latch_times[n0], 32'd1024);
         check("cont_interval_2", latch_times[n0 + 2] - latch_times[n0 + 1], 32'd1024);
      end
      n0 = n_latch;
      repeat (40) @(negedge clck);
      check("cont_stays_idle", 32'(busy), 32'd0);
      check("cont_no_extra_latch", n_latch - n0, 32'd0);

      // cnt_low at range 0: range cannot go below 0
      cnt_low = 1'b1;
      push_exp(1'b0, 2'd0, 1000);
      pulse_single();
      wait_idle(2000);
      cnt_low = 1'b0;
      check("low_r0_range", 32'(range), 32'd0);

      // Auto-range up: overflow half-way through the range-0 gate
      push_exp(1'b0, 2'd1, 100);
      c0 = clr_cnt;
      n0 = n_latch;
      pulse_single();
      inject_ovf(500);
      wait_idle(2000);
      check("up_range", 32'(range), 32'd1);
      check("up_clr_count", clr_cnt - c0, 32'd2);
      check("up_latch_count", n_latch - n0, 32'd1);
      check("up_settle_gap", latch_at - gate_last, 32'd3);
      check("up_ovf_err", 32'(ovf_err), 32'd0);

      // Saturation: range 1 -> 2 -> 3, then overflow in the 1-cycle gate
      push_exp(1'b1, 2'd3, 1);
      pulse_single();
      inject_ovf(1);
      inject_ovf(1);
      inject_ovf(1);
      wait_idle(2000);
      check("sat_range", 32'(range), 32'd3);
      check("sat_ovf_err", 32'(ovf_err), 32'd1);

      // Reset mid-GATE, with range=3 and ovf_err=1 beforehand
      n0 = n_latch;
      pulse_single();
      wait_gate_cycles(1);
      rst_n = 1'b0;
      #1;
      check("rstg_gate", 32'(gate), 32'd0);
      check("rstg_busy", 32'(busy), 32'd0);
      check("rstg_range", 32'(range), 32'd0);
      check("rstg_ovf_err", 32'(ovf_err), 32'd0);
      repeat (3) @(negedge clck);
      rst_n = 1'b1;
      repeat (40) @(negedge clck);
      check("rstg_no_latch", n_latch - n0, 32'd0);
      check("rstg_idle", 32'(busy), 32'd0);

      // Auto-range down in run mode: reach range 2, cnt_low during LATCH
      push_exp(1'b0, 2'd2, 10);
      push_exp(1'b0, 2'd1, 100);
      cnt_low = 1'b1;
      @(negedge clck);
      run = 1'b1;
      inject_ovf(5);
      inject_ovf(5);
      wait_latch(2000);
      @(negedge clck);
      cnt_low = 1'b0;
      check("down_range_after", 32'(range), 32'd1);
      wait_gate_cycles(1);
      run = 1'b0;
      wait_idle(2000);
      check("down_range_final", 32'(range), 32'd1);

      check("queue_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/freq_gate_sequencer.md
Name: freq_gate_sequencer

Overview:
- Sequences the frequency-counter datapath through repeated measurement cycles.
- Each cycle: clear the edge counter, open the gate for a fixed window, let the sigin synchronizer flush, latch the count for the digit/segment display, then hold the display.
- Auto-ranges the gate length between four decades, using overflow and low-count flags from the counter.
- Sits between the top-level control inputs and the counter/display datapath. It is the sole driver of gate, clear and latch.

Parameters:
- GATE_BASE, 1000: gate length in clck cycles at range 0. Must be a multiple of 1000. Range r uses GATE_BASE/10^r, so the defaults are 1000/100/10/1.
- SETTLE_CYCLES, 2: idle cycles between gate close and latch, for sigin synchronizer flush. Must be ≥1.
- HOLD_CYCLES, 20: display hold time after latch. Must be ≥1.
- TW, 32: width of the internal cycle timer. It must hold max(GATE_BASE, HOLD_CYCLES).

Ports:
- clck, in, 1: system clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- run, in, 1: continuous mode; level-sensitive.
- single, in, 1: one-shot start; a 1-cycle pulse, sampled in IDLE only.
- cnt_ovf, in, 1: counter saturated; meaningful only while gate=1.
- cnt_low, in, 1: count below 10% of full scale; sampled in the LATCH cycle.
- gate, out, 1: counter enable window.
- cnt_clr, out, 1: synchronous clear pulse to the counter.
- latch, out, 1: display register load pulse.
- done, out, 1: measurement-complete pulse; coincident with latch.
- busy, out, 1: high in every state except IDLE.
- range, out, 2: current gate decade (0 = longest gate).
- ovf_err, out, 1: last latched value saturated at range 3.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE, timer = 0, range = 0, ovf_err = 0.
  - All pulse/level outputs are 0.
  - Takes effect immediately mid-cycle. No latch is issued for an aborted measurement.
- Outputs are decoded from the registered state only. There is no combinational path from inputs to outputs.
- State machine:
  - IDLE: (run | single) = 1 → CLEAR. Otherwise stay in IDLE.
  - CLEAR: exactly 1 cycle with cnt_clr=1. Loads timer = GATE_BASE/10^range. Next state is GATE.
  - GATE:
    - gate=1 while the timer decrements each cycle.
    - Gate width is exactly GATE_BASE/10^range cycles.
    - When the timer expires → SETTLE.
  - Overflow during GATE (cnt_ovf=1):
    - If range<3: range+1, then → CLEAR immediately (restart, no latch).
    - If range==3: set an internal sat flag, then → SETTLE.
  - SETTLE: SETTLE_CYCLES cycles with all pulses 0. Then → LATCH.
  - LATCH: 1 cycle with latch=1 and done=1.
    - ovf_err is updated to the sat flag in the same cycle.
    - If cnt_low=1 and range>0 and sat=0: range-1, taking effect from the next CLEAR.
    - Then → HOLD.
  - HOLD: HOLD_CYCLES cycles. At expiry: → CLEAR if run=1, else → IDLE.
- run deasserted mid-measurement: the current cycle completes, including latch. The block stops only at the HOLD exit.
- single while busy: ignored.
- cnt_ovf and timer expiry in the same GATE cycle: overflow takes priority (range+1 restart, or sat).
- range saturates at 0 and 3. There is no wrap-around.
- cnt_ovf is ignored outside GATE.
- cnt_low is ignored outside LATCH.
- sat clears on each CLEAR entry.

Test Plan:
- Single shot at range 0:
  - Stimulus: defaults; single pulsed at edge t.
  - Required: cnt_clr high at t+1; gate high t+2..t+1001 (1000 cycles); latch=done=1 at t+1004; busy=0 from t+1025; range stays 0.
- Auto-range up:
  - Stimulus: cnt_ovf asserted at GATE cycle 500 of range 0.
  - Required: no latch; range=1; cnt_clr pulses again; a new 100-cycle gate follows; latch occurs after 2 settle cycles with ovf_err=0.
- Saturation:
  - Stimulus: range forced up to 3 by repeated overflows; cnt_ovf asserted again in the 1-cycle gate.
  - Required: latch issued with ovf_err=1; range stays 3.
- Auto-range down:
  - Stimulus: run=1 at range 2; cnt_low=1 during LATCH.
  - Required: the next gate is 100 cycles and range=1.
  - Stimulus: cnt_low=1 at range 0.
  - Required: range stays 0.
- Continuous mode and stop:
  - Stimulus: run=1 over 3 measurements at range 0; run dropped during the 3rd GATE.
  - Required: exactly 3 latch pulses, 1024 cycles apart (latch to latch); IDLE after the 3rd HOLD.
- Reset mid-GATE:
  - Stimulus: rst_n pulled low between edges.
  - Required: gate, busy, range, ovf_err = 0 immediately; no latch; after release, IDLE until the next start.
